// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: read-owner tags and
// the chip-enable encodings driven onto mem_ce.
package mem_arbiter_pkg;

  // Owner of the read whose data returns in the following cycle
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_INST = 2'b01,
    OWN_DATA = 2'b10
  } owner_e;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch request/return, data request/return and
// the single synchronous memory port. The arbiter uses the slave modport;
// the surrounding pipeline/memory (or a bench) uses the master modport.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  // Fetch side
  logic              ice;
  logic [ADDR_W-1:0] iaddr;
  logic [DATA_W-1:0] inst;
  logic              inst_valid;
  logic              stall_if;

  // Data side
  logic              dce;
  logic [3:0]        dwe;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              stall_mem;

  // Memory port
  logic              mem_ce;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  ice, iaddr, dce, dwe, daddr, din, mem_rdata,
    output inst, inst_valid, stall_if, dout, dout_valid, stall_mem,
           mem_ce, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output ice, iaddr, dce, dwe, daddr, din, mem_rdata,
    input  inst, inst_valid, stall_if, dout, dout_valid, stall_mem,
           mem_ce, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_starve_cnt.sv
// arb_starve_cnt: counts consecutive data grants taken while a fetch is
// waiting and raises force_o once STARVE_MAX is reached, handing the next
// cycle to the fetch. Only instantiated when ARB_STARVE_GUARD_EN is defined.
module arb_starve_cnt #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ice_i,
  input  logic gnt_d_i,
  input  logic gnt_i_i,
  output logic force_o
);

  localparam logic [3:0] CntMax = 4'(STARVE_MAX);

  logic [3:0] cnt_q, cnt_d;

  // Next count: clear once the fetch is served or withdrawn, else saturate up
  always_comb begin
    cnt_d = cnt_q;
    if (gnt_i_i || !ice_i) begin
      cnt_d = '0;
    end else if (gnt_d_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_o = (cnt_q == CntMax);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous single-port memory (1-cycle read
// latency) between instruction fetch and the MEM stage. Data wins by
// default; the read owner is tagged for one cycle so returning data is
// steered to inst or dout with a matching valid.
// Optional macro ARB_STARVE_GUARD_EN adds a starvation guard that forces a
// fetch grant after STARVE_MAX consecutive data grants against a pending fetch.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic           cpu_clk_50M,
  input  logic           cpu_rst,
  mem_arbiter_if.slave   bus
);

  logic   gnt_d, gnt_i, force_i;
  logic   inst_vld, dout_vld;
  owner_e rd_owner_q, rd_owner_d;

  // Grants are masked while in reset so the memory sees no access
  assign gnt_d = !cpu_rst && bus.dce && !force_i;
  assign gnt_i = !cpu_rst && bus.ice && !gnt_d;

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk_i   (cpu_clk_50M),
    .rst_i   (cpu_rst),
    .ice_i   (bus.ice),
    .gnt_d_i (gnt_d),
    .gnt_i_i (gnt_i),
    .force_o (force_i)
  );
`else
  logic unused_starve;
  assign force_i       = 1'b0;
  assign unused_starve = ^STARVE_MAX;
`endif

  // Memory port mux: granted requester drives the port, idle port is all-zero
  always_comb begin
    bus.mem_ce    = CHIP_DISABLE;
    bus.mem_we    = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (gnt_d) begin
      bus.mem_ce    = CHIP_ENABLE;
      bus.mem_we    = bus.dwe;
      bus.mem_addr  = bus.daddr;
      bus.mem_wdata = bus.din;
    end else if (gnt_i) begin
      bus.mem_ce    = CHIP_ENABLE;
      bus.mem_addr  = bus.iaddr;
    end
  end

  // Owner of this cycle's read; stores need no return so they tag NONE
  always_comb begin
    rd_owner_d = OWN_NONE;
    if (gnt_i) begin
      rd_owner_d = OWN_INST;
    end else if (gnt_d && (bus.dwe == 4'b0000)) begin
      rd_owner_d = OWN_DATA;
    end
  end

  // Owner tag register, one deep to match the memory read latency
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      rd_owner_q <= OWN_NONE;
    end else begin
      rd_owner_q <= rd_owner_d;
    end
  end

  // Reset also suppresses a valid from a read granted the cycle before
  assign inst_vld = !cpu_rst && (rd_owner_q == OWN_INST);
  assign dout_vld = !cpu_rst && (rd_owner_q == OWN_DATA);

  assign bus.inst_valid = inst_vld;
  assign bus.inst       = inst_vld ? bus.mem_rdata : '0;
  assign bus.dout_valid = dout_vld;
  assign bus.dout       = dout_vld ? bus.mem_rdata : '0;

  assign bus.stall_if  = !cpu_rst && bus.ice && !gnt_i;
  assign bus.stall_mem = !cpu_rst && bus.dce && !gnt_d;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural 1-cycle synchronous memory, a per-cycle
// grant/stall model and a return-data scoreboard fed at grant time.
module tb_mem_arbiter;

  localparam int STARVE_MAX = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct {
    logic [1:0]  kind;   // 0 none, 1 inst, 2 data
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .cpu_clk_50M (clk),
    .cpu_rst     (rst),
    .bus         (bus)
  );

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          m_cnt = 0;

  // Behavioural synchronous memory seen through the DUT's memory port
  always @(posedge clk) begin
    if (bus.mem_ce) begin
      if (bus.mem_we[0]) mem[bus.mem_addr[9:2]][7:0]   = bus.mem_wdata[7:0];
      if (bus.mem_we[1]) mem[bus.mem_addr[9:2]][15:8]  = bus.mem_wdata[15:8];
      if (bus.mem_we[2]) mem[bus.mem_addr[9:2]][23:16] = bus.mem_wdata[23:16];
      if (bus.mem_we[3]) mem[bus.mem_addr[9:2]][31:24] = bus.mem_wdata[31:24];
      if (bus.mem_we == 4'b0000) bus.mem_rdata <= mem[bus.mem_addr[9:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  // One clock cycle: drive, check returns and port, predict next return
  task automatic cyc(input logic r, input logic ic, input logic [31:0] ia,
                     input logic dc, input logic [3:0] we, input logic [31:0] da,
                     input logic [31:0] dd);
    exp_t e, nx;
    logic frc, gd, gi;
    rst = r; bus.ice = ic; bus.iaddr = ia;
    bus.dce = dc; bus.dwe = we; bus.daddr = da; bus.din = dd;
    #3;
    e.kind = 2'd0; e.data = 32'h0;
    if (sbq.size() > 0) e = sbq.pop_front();
    if (r) e.kind = 2'd0;
    chk("inst_valid", 32'(bus.inst_valid), 32'(e.kind == 2'd1));
    chk("inst",       bus.inst, (e.kind == 2'd1) ? e.data : 32'h0);
    chk("dout_valid", 32'(bus.dout_valid), 32'(e.kind == 2'd2));
    chk("dout",       bus.dout, (e.kind == 2'd2) ? e.data : 32'h0);

    frc = GUARD && (m_cnt == STARVE_MAX);
    gd  = !r && dc && !frc;
    gi  = !r && ic && !gd;
    chk("mem_ce",    32'(bus.mem_ce), 32'(gd || gi));
    chk("mem_addr",  bus.mem_addr, gd ? da : (gi ? ia : 32'h0));
    chk("mem_we",    32'(bus.mem_we), gd ? 32'(we) : 32'h0);
    chk("mem_wdata", bus.mem_wdata, gd ? dd : 32'h0);
    chk("stall_if",  32'(bus.stall_if), 32'(!r && ic && !gi));
    chk("stall_mem", 32'(bus.stall_mem), 32'(!r && dc && !gd));

    nx.kind = gi ? 2'd1 : ((gd && we == 4'b0000) ? 2'd2 : 2'd0);
    nx.data = gi ? ref_mem[ia[9:2]] : ref_mem[da[9:2]];
    sbq.push_back(nx);

    @(posedge clk);
    if (gd && we != 4'b0000) begin
      for (int b = 0; b < 4; b++)
        if (we[b]) ref_mem[da[9:2]][8*b +: 8] = dd[8*b +: 8];
    end
    if (r || gi || !ic)                      m_cnt = 0;
    else if (gd && (m_cnt != STARVE_MAX))    m_cnt = m_cnt + 1;
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'(i) * 32'h9E3779B1;
      ref_mem[i] = 32'(i) * 32'h9E3779B1;
    end
    mem[0]  = 32'h11;       ref_mem[0]  = 32'h11;
    mem[1]  = 32'h22;       ref_mem[1]  = 32'h22;
    mem[2]  = 32'h33;       ref_mem[2]  = 32'h33;
    mem[4]  = 32'h5555AAAA; ref_mem[4]  = 32'h5555AAAA;
    mem[8]  = 32'h12345678; ref_mem[8]  = 32'h12345678;
    mem[64] = 32'hCAFEF00D; ref_mem[64] = 32'hCAFEF00D;
    bus.mem_rdata = 32'h0;

    // Reset with both requests raised: everything masked
    cyc(1'b1, 1'b1, 32'h4, 1'b1, 4'h0, 32'h100, 32'h0);
    cyc(1'b1, 1'b1, 32'h4, 1'b1, 4'h0, 32'h100, 32'h0);

    // Fetch only
    cyc(1'b0, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    cyc(1'b0, 1'b1, 32'h4, 1'b0, 4'h0, 32'h0, 32'h0);
    cyc(1'b0, 1'b1, 32'h8, 1'b0, 4'h0, 32'h0, 32'h0);
    idle();

    // Collision, then the fetch retries once dce drops
    cyc(1'b0, 1'b1, 32'h10, 1'b1, 4'h0, 32'h100, 32'h0);
    cyc(1'b0, 1'b1, 32'h10, 1'b0, 4'h0, 32'h0, 32'h0);
    idle();

    // Partial store followed by a load of the same word
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 4'b0011, 32'h20, 32'hAABBCCDD);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 4'b0000, 32'h20, 32'h0);
    idle();

    // Sustained contention
    for (int i = 0; i < 12; i++)
      cyc(1'b0, 1'b1, 32'h8, 1'b1, 4'h0, 32'h100, 32'h0);
    idle();

    // Reset arriving the cycle after a fetch grant
    cyc(1'b0, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    idle();

    // Mixed random traffic
    for (int i = 0; i < 80; i++) begin
      cyc(($urandom_range(0, 19) == 0),
          1'($urandom_range(0, 1)), {22'h0, 8'($urandom), 2'b00},
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
          {22'h0, 8'($urandom), 2'b00}, $urandom);
    end
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
